// File: rtl/fft_frame_writer.sv
// fft_frame_writer
// Collects one frame of 2**ADDR_WIDTH samples from a valid/ready stream and
// writes them into a frame RAM, optionally in bit-reversed address order so a
// downstream FFT stage can read the frame in natural order. Once a frame is
// complete the block stops accepting samples and holds frame_valid until the
// FFT stage acknowledges it. Framing errors (s_last early or missing) are
// recorded in a sticky flag that only reset clears.
module fft_frame_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int BITREV_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic [15:0]           frame_cnt,
    output logic                  len_err
);

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_addr_map;
    logic                    w_accept;
    logic                    w_cnt_last;
    logic                    w_frame_done;

    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_frame_valid;
    logic [15:0]             r_frame_cnt;
    logic                    r_len_err;

    // Mirror the bit order of a sample index to form its RAM address.
    function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] idx);
        logic [ADDR_WIDTH-1:0] rev;
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            rev[b] = idx[ADDR_WIDTH-1-b];
        end
        return rev;
    endfunction

    // Ready is gated by rst so upstream never sees a handshake while in reset.
    assign s_ready      = (r_state == ST_FILL) && !rst;
    assign w_accept     = s_valid && s_ready;
    assign w_cnt_last   = (r_cnt == CNT_MAX);
    assign w_frame_done = (r_state == ST_HOLD) && frame_ack;

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign frame_valid  = r_frame_valid;
    assign frame_cnt    = r_frame_cnt;
    assign len_err      = r_len_err;

    // Select the RAM address for the current sample index.
    always_comb begin
        w_addr_map = r_cnt;
        if (BITREV_EN != 0) begin
            w_addr_map = bit_reverse(r_cnt);
        end else begin
            w_addr_map = r_cnt;
        end
    end

    // Next-state logic: fill a whole frame, one flush cycle, then hold until acknowledged.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_accept && w_cnt_last) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    w_state_nxt = ST_FILL;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sample index, registered RAM write port, frame status and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= {ADDR_WIDTH{1'b0}};
            r_wr_en       <= 1'b0;
            r_wr_addr     <= {ADDR_WIDTH{1'b0}};
            r_wr_data     <= {DATA_WIDTH{1'b0}};
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_len_err     <= 1'b0;
        end else begin
            r_wr_en       <= w_accept;
            r_frame_valid <= (w_state_nxt == ST_HOLD);
            if (w_accept) begin
                r_wr_addr <= w_addr_map;
                r_wr_data <= s_data;
                if (w_cnt_last) begin
                    // Final slot of the frame: wrap and flag a missing s_last.
                    r_cnt <= {ADDR_WIDTH{1'b0}};
                    if (!s_last) begin
                        r_len_err <= 1'b1;
                    end
                end else if (s_last) begin
                    // Short frame: keep the write, restart the frame, flag it.
                    r_cnt     <= {ADDR_WIDTH{1'b0}};
                    r_len_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + ADDR_WIDTH'(1);
                end
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/fft_frame_writer.md
FFT_FRAME_WRITER -- requirements
Module: fft_frame_writer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the frame length 2**ADDR_WIDTH and the write-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, giving the sample width ({re[31:0], im[31:0]}).
REQ-003 The block SHALL have parameter BITREV_EN, default 1; 1 = bit-reversed write addresses, 0 = natural order.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  1  upstream sample valid.
REQ-007 s_data  input  DATA_WIDTH  upstream sample.
REQ-008 s_last  input  1  marks the final sample of a frame.
REQ-009 s_ready  output  1  block accepts a sample this cycle.
REQ-010 wr_en  output  1  RAM write strobe.
REQ-011 wr_addr  output  ADDR_WIDTH  RAM write address.
REQ-012 wr_data  output  DATA_WIDTH  RAM write data.
REQ-013 frame_valid  output  1  complete frame resident in RAM.
REQ-014 frame_ack  input  1  single-cycle pulse from the FFT stage: frame consumed, buffer released.
REQ-015 frame_cnt  output  16  count of completed frames.
REQ-016 len_err  output  1  sticky framing-error flag.

Function
REQ-017 Handshake: a sample SHALL be accepted on any rising clk edge where s_valid=1 and s_ready=1.
REQ-018 The FSM SHALL have three states: FILL (s_ready=1), FLUSH (s_ready=0, one cycle), HOLD (s_ready=0, frame_valid=1).
REQ-019 In FILL, the sample index cnt (ADDR_WIDTH bits) SHALL start at 0 and increment by 1 per accepted sample.
REQ-020 For each accepted sample, the block SHALL register wr_en=1, wr_data=s_data, and wr_addr = bit-reverse(cnt) when BITREV_EN=1, else cnt, valid in the cycle after acceptance (latency 1).
REQ-021 In cycles with no acceptance, wr_en SHALL be 0; wr_addr and wr_data SHALL hold their last values.
REQ-022 On acceptance with cnt = 2**ADDR_WIDTH-1, the FSM SHALL go FILL->FLUSH and cnt SHALL wrap to 0.
REQ-023 FLUSH SHALL last exactly one cycle, coinciding with the final wr_en pulse, and SHALL then go to HOLD; frame_valid therefore asserts one cycle after the final write strobe.
REQ-024 In HOLD, frame_valid=1 and s_ready=0; frame_ack=1 SHALL cause HOLD->FILL, deassert frame_valid on the next cycle, and increment frame_cnt modulo 2**16.
REQ-025 frame_ack SHALL be ignored in FILL and FLUSH.
REQ-026 Early s_last (accepted with cnt < 2**ADDR_WIDTH-1): the sample SHALL still be written, cnt SHALL reset to 0, the FSM SHALL stay in FILL, len_err SHALL set, and frame_cnt SHALL NOT increment.
REQ-027 Missing s_last (the final sample accepted with s_last=0): the frame SHALL complete normally and len_err SHALL set.
REQ-028 len_err SHALL clear only on rst.

Reset
REQ-029 While rst=1 at a clk edge: FSM=FILL, cnt=0, wr_en=0, wr_addr=0, wr_data=0, frame_valid=0, frame_cnt=0, len_err=0.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial or held frame with no further wr_en pulse.
REQ-031 s_ready SHALL be 0 during reset; after rst falls it is 1 (FILL).

Verification
REQ-032 Full frame with BITREV_EN=1 and s_valid held high, data = index 0..255, s_last on 255 -> wr_addr sequence 0,128,64,192,...,255; wr_data[k] = k; frame_valid rises 2 cycles after the 256th acceptance; len_err=0.
REQ-033 Frame held in HOLD for 10 cycles, then a 1-cycle frame_ack -> s_ready=0 throughout HOLD; frame_cnt 0->1; s_ready=1 the next cycle; a second frame completes -> frame_cnt=2.
REQ-034 s_valid toggled randomly at 50% with BITREV_EN=0 -> wr_addr increments 0..255 only on strobes; no sample is lost or duplicated.
REQ-035 s_last on sample 99 -> len_err=1, no frame_valid; the next 256 samples form a valid frame with frame_cnt=1 and len_err still 1.
REQ-036 rst pulsed at sample 150 -> all outputs at reset values the next cycle; the following frame starts at wr_addr 0.
REQ-037 frame_ack pulsed during FILL -> no effect; frame_cnt unchanged.
